// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter; cnt0/cnt1 exist only with
// FIFO_ARB_STATS_EN. The arbiter uses the slave modport, its environment the master one.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wdata;
  logic [1:0]        grant;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]       cnt0;
  logic [15:0]       cnt1;
`endif

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full, fifo_almost_full,
    input  req0_ready, req1_ready, fifo_wr_en, fifo_wdata, grant, busy
`ifdef FIFO_ARB_STATS_EN
    , input cnt0, cnt1
`endif
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full, fifo_almost_full,
    output req0_ready, req1_ready, fifo_wr_en, fifo_wdata, grant, busy
`ifdef FIFO_ARB_STATS_EN
    , output cnt0, cnt1
`endif
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two valid/ready producers.
// Define FIFO_ARB_STATS_EN to add the per-requester accepted-word counters cnt0/cnt1.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e              state_q;
  logic                rr_q;
  logic [BurstW-1:0]   beats_q;
  logic                wr_en_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          grant_q;
  logic                busy_q;

  logic flags_ok, ready0, ready1, acc0, acc1, last_beat, dry;

  // Ready never looks at valid, so producers may legally wait for ready.
  assign flags_ok  = !bus.fifo_almost_full && !bus.fifo_full;
  assign ready0    = (state_q == StGnt0) && flags_ok;
  assign ready1    = (state_q == StGnt1) && flags_ok;
  assign acc0      = ready0 && bus.req0_valid;
  assign acc1      = ready1 && bus.req1_valid;
  assign last_beat = (acc0 || acc1) && (beats_q == BurstW'(MAX_BURST - 1));
  assign dry       = (ready0 && !bus.req0_valid) || (ready1 && !bus.req1_valid);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      beats_q <= '0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      wr_en_q <= acc0 || acc1;
      if (acc0) begin
        wdata_q <= bus.req0_data;
      end else if (acc1) begin
        wdata_q <= bus.req1_data;
      end
      unique case (state_q)
        StIdle: begin
          if (!bus.fifo_almost_full && (bus.req0_valid || bus.req1_valid)) begin
            beats_q <= '0;
            busy_q  <= 1'b1;
            if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
              state_q <= StGnt0;
              grant_q <= 2'b01;
            end else begin
              state_q <= StGnt1;
              grant_q <= 2'b10;
            end
          end
        end
        StGnt0, StGnt1: begin
          if (acc0 || acc1) begin
            beats_q <= beats_q + 1'b1;
          end
          if (last_beat || dry) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            rr_q    <= (state_q == StGnt0);
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0) cnt0_q <= cnt0_q + 16'd1;
      if (acc1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed plan steps plus a random phase, all compared each
// cycle against a transaction-level model of owner/beat-count/preference.
module tb_fifo_wr_arbiter;
  localparam int unsigned DW = 8;
  localparam int MB = 16;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  fifo_wr_arbiter_if #(.DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit en0, en1, af, full, v0, v1;

  // Model: owner -1 = idle, otherwise index of the producer holding the port.
  int m_owner = -1, m_beats = 0, m_rr = 0, m_wr = 0, m_wdata = 0;
  int m_cnt0 = 0, m_cnt1 = 0, n_acc = 0;

  int g_log[$];
  int d_log[$];
  int run_val[$];
  int run_len[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit r0, r1;
    int acc;
    v0 = en0 && (q0.size() != 0);
    v1 = en1 && (q1.size() != 0);
    bus.req0_valid       = v0;
    bus.req0_data        = v0 ? q0[0] : 8'h00;
    bus.req1_valid       = v1;
    bus.req1_data        = v1 ? q1[0] : 8'h00;
    bus.fifo_almost_full = af;
    bus.fifo_full        = full;
    @(negedge sys_clk);
    r0 = (m_owner == 0) && !af && !full;
    r1 = (m_owner == 1) && !af && !full;
    chk("ready0", {31'd0, bus.req0_ready}, {31'd0, r0});
    chk("ready1", {31'd0, bus.req1_ready}, {31'd0, r1});
    chk("grant", {30'd0, bus.grant}, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("busy", {31'd0, bus.busy}, (m_owner < 0) ? 0 : 1);
    chk("wr_en", {31'd0, bus.fifo_wr_en}, m_wr);
    chk("wdata", {24'd0, bus.fifo_wdata}, m_wdata);
`ifdef FIFO_ARB_STATS_EN
    chk("cnt0", {16'd0, bus.cnt0}, m_cnt0);
    chk("cnt1", {16'd0, bus.cnt1}, m_cnt1);
`endif
    g_log.push_back(int'(bus.grant));
    if (bus.fifo_wr_en === 1'b1) d_log.push_back(int'(bus.fifo_wdata));
    if (!sys_rst_n) begin
      m_owner = -1; m_beats = 0; m_rr = 0; m_wr = 0; m_wdata = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      acc = -1;
      if (r0 && v0) acc = 0;
      else if (r1 && v1) acc = 1;
      m_wr = (acc >= 0) ? 1 : 0;
      if (acc == 0) begin
        m_wdata = int'(q0.pop_front());
        m_cnt0 = (m_cnt0 + 1) % 65536;
      end
      if (acc == 1) begin
        m_wdata = int'(q1.pop_front());
        m_cnt1 = (m_cnt1 + 1) % 65536;
      end
      if (acc >= 0) n_acc++;
      if (m_owner < 0) begin
        if (!af && (v0 || v1)) begin
          m_owner = (v0 && v1) ? m_rr : (v0 ? 0 : 1);
          m_beats = 0;
        end
      end else begin
        if (acc >= 0) m_beats++;
        if (m_beats == MB || (m_owner == 0 ? (r0 && !v0) : (r1 && !v1))) begin
          m_rr = 1 - m_owner;
          m_owner = -1;
        end
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    cycle();
    sys_rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", q0.size() + q1.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic get_runs();
    run_val.delete();
    run_len.delete();
    for (int i = 0; i < g_log.size(); i++) begin
      if (g_log[i] != 0) begin
        if (i > 0 && g_log[i-1] == g_log[i]) run_len[run_len.size()-1] += 1;
        else begin
          run_val.push_back(g_log[i]);
          run_len.push_back(1);
        end
      end
    end
  endtask

  initial begin
    int start, n, wr_before, c0, c1;
    en0 = 0; en1 = 0; af = 0; full = 0;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_data = 0; bus.req1_data = 0;
    bus.fifo_almost_full = 0; bus.fifo_full = 0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (2) cycle();  // reset state checked by the model comparisons

    // Req0 alone, 20 words: 16-beat burst, gap, 4 beats plus the dry cycle.
    g_log.delete(); d_log.delete();
    for (int i = 0; i < 20; i++) q0.push_back(8'(i));
    en0 = 1;
    drain(100);
    chk("t1_count", d_log.size(), 20);
    for (int i = 0; i < d_log.size() && i < 20; i++) chk("t1_order", d_log[i], i);
    get_runs();
    chk("t1_runs", run_len.size(), 2);
    if (run_len.size() == 2) begin
      chk("t1_run0", run_len[0], 16);
      chk("t1_run1", run_len[1], 5);
    end

    // Both producers saturating after reset: alternating 16-beat bursts, req0 first.
    pulse_reset();
    g_log.delete(); d_log.delete();
    for (int i = 0; i < 48; i++) begin
      q0.push_back(8'(i));
      q1.push_back(8'(8'h80 + i));
    end
    en0 = 1; en1 = 1;
    drain(200);
    get_runs();
    chk("t2_runs", run_val.size(), 6);
    for (int i = 0; i < run_val.size(); i++) begin
      chk("t2_owner", run_val[i], (i % 2 == 0) ? 1 : 2);
      chk("t2_len", run_len[i], 16);
    end
    chk("t2_count", d_log.size(), 96);
    c0 = 0; c1 = 0;
    for (int i = 0; i < d_log.size(); i++) begin
      if (d_log[i] < 8'h80) begin
        chk("t2_seq0", d_log[i], c0);
        c0++;
      end else begin
        chk("t2_seq1", d_log[i], 8'h80 + c1);
        c1++;
      end
    end

    // almost_full for 5 cycles after beat 6: one in-flight write, burst still ends at 16.
    pulse_reset();
    g_log.delete(); d_log.delete();
    for (int i = 0; i < 20; i++) q0.push_back(8'(8'h40 + i));
    en0 = 1; en1 = 0;
    start = n_acc; n = 0;
    while (n_acc - start < 6 && n < 50) begin
      cycle();
      n++;
    end
    chk("t3_beats", n_acc - start, 6);
    af = 1;
    wr_before = d_log.size();
    repeat (5) cycle();
    chk("t3_stall_wr", d_log.size() - wr_before, 1);
    af = 0;
    drain(100);
    get_runs();
    chk("t3_run0", (run_len.size() > 0) ? run_len[0] : 0, 21);
    chk("t3_count", d_log.size(), 20);

    // Req1 preferred, runs dry after 3 beats; req0 waiting gets the next grant.
    g_log.delete(); d_log.delete();
    for (int i = 0; i < 3; i++) q1.push_back(8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) q0.push_back(8'(8'hD0 + i));
    en0 = 1; en1 = 1;
    drain(100);
    get_runs();
    chk("t4_runs", run_val.size(), 2);
    if (run_val.size() == 2) begin
      chk("t4_first", run_val[0], 2);
      chk("t4_first_len", run_len[0], 4);
      chk("t4_second", run_val[1], 1);
      chk("t4_second_len", run_len[1], 6);
    end

    // Reset at beat 8: that beat is dropped, next grant goes to req0.
    pulse_reset();
    g_log.delete(); d_log.delete();
    for (int i = 0; i < 20; i++) q0.push_back(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) q1.push_back(8'(8'hE0 + i));
    en0 = 1; en1 = 0;
    start = n_acc; n = 0;
    while (n_acc - start < 7 && n < 50) begin
      cycle();
      n++;
    end
    pulse_reset();
    en1 = 1;
    g_log.delete();
    drain(100);
    chk("t5_post_rst_grant", g_log[0], 0);
    get_runs();
    chk("t5_next_owner", (run_val.size() > 0) ? run_val[0] : 0, 1);
    chk("t5_count", d_log.size(), 24);

`ifdef FIFO_ARB_STATS_EN
    pulse_reset();
    for (int i = 0; i < 20; i++) q0.push_back(8'(i));
    for (int i = 0; i < 7; i++) q1.push_back(8'(8'h70 + i));
    en0 = 1; en1 = 1;
    drain(100);
    chk("st_cnt0", {16'd0, bus.cnt0}, 20);
    chk("st_cnt1", {16'd0, bus.cnt1}, 7);
    pulse_reset();
    cycle();
    chk("st_cnt0_rst", {16'd0, bus.cnt0}, 0);
    chk("st_cnt1_rst", {16'd0, bus.cnt1}, 0);
`endif

    // Random traffic, flags and occasional reset against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0 && q0.size() < 40) q0.push_back(8'($urandom));
      if ($urandom_range(3) == 0 && q1.size() < 40) q1.push_back(8'($urandom));
      en0 = ($urandom_range(3) != 0);
      en1 = ($urandom_range(3) != 0);
      af = ($urandom_range(6) == 0);
      full = af && ($urandom_range(2) == 0);
      sys_rst_n = ($urandom_range(150) != 0);
      cycle();
    end
    sys_rst_n = 1; af = 0; full = 0; en0 = 1; en1 = 1;
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit FIFO between two producer streams. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and forwards accepted words to the FIFO `wr_en`/`din` with one registered cycle of latency. Backpressure comes from the FIFO `almost_full`/`full` flags. The block sits between the producers and the FIFO instance on the shared `sys_clk` domain.

## Interface
Parameters:
- `DATA_W`, default 8: data width; must equal the FIFO `din` width.
- `MAX_BURST`, default 16: maximum beats per grant; must be ≥1.

Ports:
- `sys_clk`, in, 1: the only clock; all logic is rising-edge.
- `sys_rst_n`, in, 1: reset, synchronous, active-low.
- `req0_valid`, in, 1: producer 0 has a word.
- `req0_data`, in, DATA_W: producer 0 word.
- `req0_ready`, out, 1: producer 0 word accepted this cycle when valid is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for producer 1.
- `fifo_full`, in, 1: FIFO `full`.
- `fifo_almost_full`, in, 1: FIFO `almost_full`.
- `fifo_wr_en`, out, 1: FIFO write enable (registered).
- `fifo_wdata`, out, DATA_W: FIFO `din` (registered).
- `grant`, out, 2: one-hot current owner; `2'b00` when idle (registered).
- `busy`, out, 1: high whenever the state is not IDLE (registered).
- `cnt0`, `cnt1`, out, 16 each: accepted-word counters; present only with `FIFO_ARB_STATS_EN`.

## Operation
- FSM states: IDLE, GNT0, GNT1. Round-robin pointer `rr` holds the preferred requester; reset value 0.
- IDLE transitions, requiring `!fifo_almost_full`:
  - Only one requester valid: grant it.
  - Both valid: grant `rr`.
  - No requester valid, or `fifo_almost_full` high: stay in IDLE.
- GNTx, acceptance:
  - `reqx_ready = (state==GNTx) && !fifo_almost_full && !fifo_full`. This is combinational from state and the flags only; it never depends on `reqx_valid`.
  - The other requester's ready is 0.
  - A beat is accepted when `reqx_valid && reqx_ready`.
- GNTx, burst counter:
  - Width is `$clog2(MAX_BURST+1)`. It clears on grant entry and increments on each accepted beat.
- GNTx, release to IDLE, on the cycle after any of:
  - the accepted beat count reaches MAX_BURST;
  - `reqx_valid` is low while ready is high (producer ran dry).
- On release, `rr` is set to the other requester.
- A stall from `fifo_almost_full` does not release the grant; the owner keeps the grant with ready low.
- Write path: an accepted beat drives `fifo_wr_en=1` and `fifo_wdata=reqx_data` on the next cycle. Otherwise `fifo_wr_en=0`, and `fifo_wdata` holds its last value.
- Overflow guard: `fifo_wr_en` is never asserted while the registered write is the only write in flight and `fifo_full` is high. The FIFO is configured so that `almost_full` asserts at least 1 entry before full, which covers the 1-cycle pipeline.
- Reset (synchronous, any cycle including mid-burst):
  - State becomes IDLE and `rr=0`; burst counter clears.
  - `fifo_wr_en=0`, `fifo_wdata=0`, `grant=0`, `busy=0`; both ready outputs are 0.
  - A beat accepted in the reset cycle is discarded.

## Timing
- Grant latency: requester valid in IDLE at cycle N gives `grant` and ready at N+1, first acceptance at N+1, and `fifo_wr_en` at N+2.
- Sustained throughput: 1 word per cycle within a burst.
- Arbitration gap: 1 IDLE cycle between consecutive bursts.
- Max burst: MAX_BURST consecutive beats, then a forced release.
- Flag response: `fifo_almost_full` high at cycle N drops ready in cycle N (combinational). At most one further `fifo_wr_en` follows, from the beat accepted at N-1.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - `cnt0`/`cnt1` are present; each increments by 1 per accepted beat of its requester.
  - Both reset to 0 and wrap from 0xFFFF to 0.
- `FIFO_ARB_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Req0 only, held valid, data 0x00..0x13 (20 words), FIFO empty. Required response: grant 01 for 16 beats; IDLE for 1 cycle; grant 01 for 4 beats. `fifo_wdata` sequence is 0x00..0x13 in order, each word 1 cycle after acceptance.
- Both requesters continuously valid after reset. Required response: grants alternate 01,10,01,… in 16-beat bursts starting with req0, and no word is lost or duplicated.
- Assert `fifo_almost_full` for 5 cycles mid-burst after beat 6. Required response: ready=0 for exactly those 5 cycles; grant held; exactly one `fifo_wr_en` in the first stall cycle; the burst resumes and ends at beat 16.
- Req1 drops valid after 3 beats while req0 is waiting. Required response: release to IDLE; next grant is req0; `rr` points to req0.
- Assert `sys_rst_n=0` for 1 cycle at beat 8 of a burst. Required response: the next cycle shows `grant=00`, `fifo_wr_en=0`, `busy=0`; the next grant goes to req0.
- With `FIFO_ARB_STATS_EN`, run 20 req0 words and 7 req1 words. Required response: `cnt0=20`, `cnt1=7`; after reset, both read 0.
